link_frame_ctrl: RTL and testbench



---
 rtl/link_frame_ctrl_if.sv | 32 +++
 rtl/link_frame_ctrl.sv | 128 ++++++++++++
 tb/tb_link_frame_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/link_frame_ctrl_if.sv
// Bundle between the frame sequencer and its environment.
// Handshake: each strobe is held for as long as the sequencer sits in the matching phase. A drawer finishes by
// raising its done (either a one-cycle pulse or a held level), and the sequencer samples that done only in its own phase.
interface link_frame_ctrl_if;
  logic       start;
  logic [2:0] user_input;
  logic       map_draw_done;
  logic       char_draw_done;
  logic       init;
  logic       idle;
  logic       apply_action;
  logic       draw_map;
  logic       draw_char;
  logic [2:0] action_code;
  logic       vga_sel;
  logic [7:0] frame_count;
  logic       timeout_err;
  logic       frame_overrun;
  logic [2:0] state_dbg;

  modport master (
    input  start, user_input, map_draw_done, char_draw_done,
    output init, idle, apply_action, draw_map, draw_char,
    output action_code, vga_sel, frame_count, timeout_err, frame_overrun, state_dbg
  );

  modport slave (
    output start, user_input, map_draw_done, char_draw_done,
    input  init, idle, apply_action, draw_map, draw_char,
    input  action_code, vga_sel, frame_count, timeout_err, frame_overrun, state_dbg
  );
endinterface

// File: rtl/link_frame_ctrl.sv
// Per-frame sequencer: paces the game from a free-running frame divider, strobes the character/map phases,
// owns the VGA port select and aborts hung drawers with a watchdog.
module link_frame_ctrl #(
  parameter int FRAME_DIV    = 833333,
  parameter int ACTION_DIV   = 4,
  parameter int DRAW_TIMEOUT = 65535
) (
  input  logic              clock,
  input  logic              reset,
  link_frame_ctrl_if.master bus
);
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int WD_W  = (DRAW_TIMEOUT > 1) ? $clog2(DRAW_TIMEOUT) : 1;
  localparam int ACT_W = (ACTION_DIV > 1) ? $clog2(ACTION_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(FRAME_DIV - 1);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(DRAW_TIMEOUT - 1);
  localparam logic [ACT_W-1:0] ACT_MAX = ACT_W'(ACTION_DIV - 1);

  // Encoding is visible on state_dbg; S_RESET must stay 0.
  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_INIT      = 3'd1,
    S_IDLE      = 3'd2,
    S_ACTION    = 3'd3,
    S_DRAW_MAP  = 3'd4,
    S_DRAW_CHAR = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [ACT_W-1:0] act_q, act_d;
  logic             pend_q, pend_d;
  logic [2:0]       code_q, code_d;
  logic [7:0]       fc_q, fc_d;
  logic             terr_q, terr_d;
  logic             ovr_q, ovr_d;
  logic             tick, service, in_draw, wd_expired;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RESET;
      div_q   <= '0;
      wd_q    <= '0;
      act_q   <= '0;
      pend_q  <= 1'b0;
      code_q  <= 3'b000;
      fc_q    <= 8'd0;
      terr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      wd_q    <= wd_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      fc_q    <= fc_d;
      terr_q  <= terr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    tick       = (div_q == DIV_MAX);
    div_d      = tick ? '0 : div_q + 1'b1;
    service    = (state_q == S_IDLE) && (pend_q || tick);
    in_draw    = (state_q == S_DRAW_MAP) || (state_q == S_DRAW_CHAR);
    wd_expired = in_draw && (wd_q == WD_MAX);
    state_d    = state_q;
    act_d      = act_q;
    code_d     = code_q;
    fc_d       = fc_q;
    terr_d     = terr_q;
    ovr_d      = ovr_q || (tick && pend_q && (state_q != S_IDLE));
    // A tick landing on the idle exit is absorbed by that exit rather than queued.
    if (service)   pend_d = 1'b0;
    else if (tick) pend_d = 1'b1;
    else           pend_d = pend_q;

    unique case (state_q)
      S_RESET: if (bus.start) state_d = S_INIT;
      S_INIT: begin
        fc_d    = 8'd0;
        act_d   = '0;
        state_d = S_DRAW_MAP;
      end
      S_IDLE: if (service) begin
        fc_d    = fc_q + 8'd1;
        code_d  = bus.user_input;
        act_d   = (act_q == ACT_MAX) ? '0 : act_q + 1'b1;
        state_d = ((act_q == ACT_MAX) && (bus.user_input != 3'b000)) ? S_ACTION : S_DRAW_MAP;
      end
      S_ACTION: state_d = S_DRAW_MAP;
      S_DRAW_MAP: begin
        if (bus.map_draw_done) state_d = S_DRAW_CHAR;
        else if (wd_expired) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAW_CHAR: begin
        if (bus.char_draw_done) state_d = S_IDLE;
        else if (wd_expired) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_RESET;
    endcase

    wd_d = (in_draw && (state_d == state_q)) ? wd_q + 1'b1 : '0;
  end

  always_comb begin
    bus.init          = (state_q == S_INIT);
    bus.idle          = (state_q == S_IDLE);
    bus.apply_action  = (state_q == S_ACTION);
    bus.draw_map      = (state_q == S_DRAW_MAP);
    bus.draw_char     = (state_q == S_DRAW_CHAR);
    bus.vga_sel       = (state_q == S_DRAW_CHAR);
    bus.action_code   = code_q;
    bus.frame_count   = fc_q;
    bus.timeout_err   = terr_q;
    bus.frame_overrun = ovr_q;
    bus.state_dbg     = state_q;
  end
endmodule

// File: tb/tb_link_frame_ctrl.sv
// Bench for link_frame_ctrl: directed scenarios plus randomized traffic, every cycle checked against a
// phase-level model of the frame sequencer.
module tb_link_frame_ctrl;
  localparam int FD = 100;
  localparam int AD = 2;
  localparam int DT = 50;
  localparam int P_RESET = 0, P_INIT = 1, P_IDLE = 2, P_ACT = 3, P_MAP = 4, P_CHAR = 5;
  localparam logic [4:0] ST_NONE = 5'b00000, ST_INIT = 5'b10000, ST_IDLE = 5'b01000;
  localparam logic [4:0] ST_MAP  = 5'b00010, ST_CHAR = 5'b00001;

  logic clock;
  logic reset;
  link_frame_ctrl_if ifc();

  link_frame_ctrl #(.FRAME_DIV(FD), .ACTION_DIV(AD), .DRAW_TIMEOUT(DT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {ifc.init, ifc.idle, ifc.apply_action, ifc.draw_map, ifc.draw_char};
  endfunction

  // Drawer emulation: done rises map_lat/char_lat cycles into the phase and is held until the phase ends.
  int map_lat = 10, char_lat = 10, map_cnt = 0, char_cnt = 0;
  bit noise_en = 0;
  always @(negedge clock) begin
    if (ifc.draw_map) begin
      map_cnt++;
      ifc.map_draw_done = (map_lat != 0) && (map_cnt >= map_lat);
    end else begin
      map_cnt = 0;
      ifc.map_draw_done = noise_en && ($urandom_range(0, 7) == 0);
    end
    if (ifc.draw_char) begin
      char_cnt++;
      ifc.char_draw_done = (char_lat != 0) && (char_cnt >= char_lat);
    end else begin
      char_cnt = 0;
      ifc.char_draw_done = noise_en && ($urandom_range(0, 7) == 0);
    end
  end

  // Reference model: frame ticks from the cycle count since reset, actions from the count of serviced frames,
  // watchdog as dwell time in the current phase.
  int         m_phase = P_RESET, m_cyc = 0, m_dwell = 0, m_served = 0, m_fc = 0;
  bit         m_pend = 0, m_terr = 0, m_ovr = 0, model_valid = 0;
  logic [2:0] m_code = 3'b000;

  always @(posedge clock) begin
    int  nxt;
    bit  tick, serve;
    if (reset) begin
      m_phase = P_RESET; m_cyc = 0; m_dwell = 0; m_served = 0; m_fc = 0;
      m_pend = 0; m_terr = 0; m_ovr = 0; m_code = 3'b000; model_valid = 1;
    end else begin
      tick  = ((m_cyc % FD) == FD - 1);
      m_cyc++;
      serve = (m_phase == P_IDLE) && (m_pend || tick);
      if (tick && m_pend && m_phase != P_IDLE) m_ovr = 1;
      if (serve) m_pend = 0;
      else if (tick) m_pend = 1;
      nxt = m_phase;
      case (m_phase)
        P_RESET: if (ifc.start) nxt = P_INIT;
        P_INIT: begin m_fc = 0; m_served = 0; nxt = P_MAP; end
        P_IDLE: if (serve) begin
          m_fc   = (m_fc + 1) % 256;
          m_code = ifc.user_input;
          nxt    = ((m_served % AD) == AD - 1 && ifc.user_input != 3'b000) ? P_ACT : P_MAP;
          m_served++;
        end
        P_ACT: nxt = P_MAP;
        P_MAP: if (ifc.map_draw_done) nxt = P_CHAR;
               else if (m_dwell == DT - 1) begin m_terr = 1; nxt = P_IDLE; end
        P_CHAR: if (ifc.char_draw_done) nxt = P_IDLE;
                else if (m_dwell == DT - 1) begin m_terr = 1; nxt = P_IDLE; end
        default: nxt = P_RESET;
      endcase
      if (nxt != m_phase) m_dwell = 0;
      else if (m_phase == P_MAP || m_phase == P_CHAR) m_dwell++;
      else m_dwell = 0;
      m_phase = nxt;
    end
  end

  // Scoreboard: every cycle after the first reset.
  always @(negedge clock) begin
    if (model_valid) begin
      check("strobes", strobes(), {m_phase == P_INIT, m_phase == P_IDLE, m_phase == P_ACT,
                                   m_phase == P_MAP, m_phase == P_CHAR});
      check("vga_sel", ifc.vga_sel, m_phase == P_CHAR);
      check("action_code", ifc.action_code, m_code);
      check("frame_count", ifc.frame_count, m_fc[7:0]);
      check("timeout_err", ifc.timeout_err, m_terr);
      check("frame_overrun", ifc.frame_overrun, m_ovr);
    end
  end

  // Driver tasks
  task automatic wait_strobe(input logic [4:0] pat, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (strobes() == pat) return;
    end
    check({name, "_expired"}, strobes(), pat);
  endtask

  task automatic run_frames(input int target, input int budget, output int acts, output int chars);
    acts = 0;
    chars = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (ifc.apply_action) acts++;
      if (ifc.draw_char) chars++;
      if (ifc.frame_count == target[7:0]) return;
    end
    check("frame_wait_expired", ifc.frame_count, target);
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    @(negedge clock);
    ifc.start = 1'b0;
  endtask

  initial begin
    int acts, chars;
    reset = 1'b1;
    ifc.start = 1'b0;
    ifc.user_input = 3'b000;
    repeat (3) @(negedge clock);
    check("rst_strobes", strobes(), ST_NONE);
    check("rst_state", ifc.state_dbg, 3'd0);
    check("rst_fc", ifc.frame_count, 8'd0);
    reset = 1'b0;

    // Bring-up: init for one cycle, map, char with vga_sel, then idle.
    ifc.user_input = 3'b010;
    pulse_start();
    check("init_cycle", strobes(), ST_INIT);
    @(negedge clock);
    check("first_map", strobes(), ST_MAP);
    check("map_vga", ifc.vga_sel, 1'b0);
    wait_strobe(ST_CHAR, 30, "wait_char");
    check("char_vga", ifc.vga_sel, 1'b1);
    wait_strobe(ST_IDLE, 30, "wait_idle");
    check("idle_only", strobes(), ST_IDLE);

    // Four frames moving up: action on every second frame.
    run_frames(4, 1000, acts, chars);
    check("up_actions", acts, 2);
    check("up_code", ifc.action_code, 3'b010);
    check("no_overrun", ifc.frame_overrun, 1'b0);

    // No input on the action frame; the action slot still rotates.
    ifc.user_input = 3'b000;
    run_frames(6, 400, acts, chars);
    check("none_actions", acts, 0);
    ifc.user_input = 3'b101;
    run_frames(8, 400, acts, chars);
    check("right_actions", acts, 1);
    check("right_code", ifc.action_code, 3'b101);

    // Hung map drawer: abort into idle, character draw skipped.
    map_lat = 0;
    chars = 0;
    for (int i = 0; i < 300 && !ifc.timeout_err; i++) begin
      @(negedge clock);
      if (ifc.draw_char) chars++;
    end
    check("timeout_set", ifc.timeout_err, 1'b1);
    check("timeout_idle", strobes(), ST_IDLE);
    check("timeout_no_char", chars, 0);
    map_lat = 10;
    run_frames(9, 300, acts, chars);
    wait_strobe(ST_IDLE, 100, "recover_idle");
    check("recover_fc", ifc.frame_count, 8'd9);

    // Ticks pile up while parked in reset: overrun, then exactly one frame serviced.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (210) @(negedge clock);
    check("overrun_set", ifc.frame_overrun, 1'b1);
    pulse_start();
    run_frames(1, 100, acts, chars);
    wait_strobe(ST_IDLE, 100, "overrun_idle");
    repeat (20) @(negedge clock);
    check("single_service", ifc.frame_count, 8'd1);

    // Reset in the middle of a character draw.
    char_lat = 40;
    wait_strobe(ST_CHAR, 200, "mid_char");
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_strobes", strobes(), ST_NONE);
    check("midrst_state", ifc.state_dbg, 3'd0);
    check("midrst_vga", ifc.vga_sel, 1'b0);
    check("midrst_fc", ifc.frame_count, 8'd0);
    check("midrst_code", ifc.action_code, 3'b000);
    repeat (30) @(negedge clock);
    check("parked_reset", strobes(), ST_NONE);

    // Randomized traffic: latencies beyond the watchdog, stray dones, stray starts, random resets.
    noise_en = 1;
    for (int ep = 0; ep < 40; ep++) begin
      ifc.user_input = 3'($urandom_range(0, 5));
      map_lat  = $urandom_range(0, 60);
      char_lat = $urandom_range(0, 60);
      if ($urandom_range(0, 11) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clock);
        reset = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) pulse_start();
      for (int c = 0; c < $urandom_range(50, 250); c++) begin
        @(negedge clock);
        if ($urandom_range(0, 15) == 0) ifc.user_input = 3'($urandom_range(0, 7));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "global timeout");
  end
endmodule
